// File: rtl/frame_buf_mem_if.sv
// rtl/frame_buf_mem_if.sv - write/read port bundle of the multi-bank frame buffer
interface frame_buf_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 2
) ();
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int FW = $clog2(NUM_BANKS + 1);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_ready;
    logic                  rd_ready;
    logic [FW-1:0]         frames;
    logic [BW-1:0]         wr_bank;
    logic [BW-1:0]         rd_bank;
    logic                  wr_ovf;
    logic                  rd_unf;

    modport master (
        output wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_last,
        input  rd_data, rd_valid, wr_ready, rd_ready, frames, wr_bank, rd_bank, wr_ovf, rd_unf
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_last,
        output rd_data, rd_valid, wr_ready, rd_ready, frames, wr_bank, rd_bank, wr_ovf, rd_unf
    );
endinterface

// File: rtl/frame_buf_mem.sv
// rtl/frame_buf_mem.sv - NUM_BANKS-deep frame FIFO of full frames, one write and one read per cycle
module frame_buf_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    frame_buf_mem_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int FW    = $clog2(NUM_BANKS + 1);
    localparam int PW    = BW + ADDR_WIDTH;
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [FW-1:0] FULL      = FW'(NUM_BANKS);

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS*DEPTH];

    logic [FW-1:0]         frames;
    logic [BW-1:0]         wr_bank;
    logic [BW-1:0]         rd_bank;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_ovf;
    logic                  rd_unf;

    logic                  wr_ready;
    logic                  rd_ready;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  close_frame;
    logic                  release_frame;
    logic [PW-1:0]         wr_phys;
    logic [PW-1:0]         rd_phys;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    assign wr_ready      = (frames != FULL);
    assign rd_ready      = (frames != '0);
    assign wr_acc        = !bus.wr_en && wr_ready;
    assign rd_acc        = !bus.rd_en && rd_ready;
    assign close_frame   = wr_acc && bus.wr_last;
    assign release_frame = rd_acc && bus.rd_last;

    // DEPTH is a power of two, so concatenation equals bank*DEPTH + addr
    assign wr_phys = {wr_bank, bus.wr_addr};
    assign rd_phys = {rd_bank, bus.rd_addr};

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_phys] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            frames   <= '0;
            wr_bank  <= '0;
            rd_bank  <= '0;
            wr_ovf   <= 1'b0;
            rd_unf   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_phys];
            end
            if (!bus.wr_en && !wr_ready) begin
                wr_ovf <= 1'b1;
            end
            if (!bus.rd_en && !rd_ready) begin
                rd_unf <= 1'b1;
            end
            if (close_frame && !release_frame) begin
                frames <= frames + 1'b1;
            end else if (release_frame && !close_frame) begin
                frames <= frames - 1'b1;
            end
            if (close_frame) begin
                wr_bank <= next_bank(wr_bank);
            end
            if (release_frame) begin
                rd_bank <= next_bank(rd_bank);
            end
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.frames   = frames;
    assign bus.wr_bank  = wr_bank;
    assign bus.rd_bank  = rd_bank;
    assign bus.wr_ovf   = wr_ovf;
    assign bus.rd_unf   = rd_unf;
endmodule

// File: tb/tb_frame_buf_mem.sv
// tb/tb_frame_buf_mem.sv - scoreboard bench for frame_buf_mem (2-bank main instance, 3-bank wrap instance)
module tb_frame_buf_mem;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NB    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    bit   clk_run = 1'b0;

    int total = 0;
    int bad   = 0;

    frame_buf_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();
    frame_buf_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(4),  .NUM_BANKS(3))  b3 ();

    frame_buf_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) u0 (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    frame_buf_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .NUM_BANKS(3)) u1 (
        .clk(clk), .reset(reset), .bus(b3.slave)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // reference model state
    logic [31:0] m_mem [int];
    logic [31:0] sb [$];
    int          m_frames, m_wb, m_rb;
    bit          m_wovf, m_runf;
    logic [31:0] m_rd_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("frames",   32'(bus.frames),   32'(m_frames));
        chk("wr_bank",  32'(bus.wr_bank),  32'(m_wb));
        chk("rd_bank",  32'(bus.rd_bank),  32'(m_rb));
        chk("wr_ready", 32'(bus.wr_ready), 32'(m_frames < NB));
        chk("rd_ready", 32'(bus.rd_ready), 32'(m_frames > 0));
        chk("wr_ovf",   32'(bus.wr_ovf),   32'(m_wovf));
        chk("rd_unf",   32'(bus.rd_unf),   32'(m_runf));
    endtask

    // stop the clock, pulse reset, check outputs while reset is still high
    task automatic do_reset();
        clk_run = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        m_frames = 0; m_wb = 0; m_rb = 0; m_wovf = 0; m_runf = 0; m_rd_data = '0;
        sb.delete();
        check_state();
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data",  bus.rd_data, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        clk_run = 1'b1;
    endtask

    task automatic step(input bit we_n, input int wa, input logic [31:0] wd, input bit wl,
                        input bit re_n, input int ra, input bit rl);
        bit wacc, racc;
        logic [31:0] exp;
        bus.wr_en = we_n; bus.wr_addr = AW'(wa); bus.wr_data = wd; bus.wr_last = wl;
        bus.rd_en = re_n; bus.rd_addr = AW'(ra); bus.rd_last = rl;
        wacc = !we_n && (m_frames < NB);
        racc = !re_n && (m_frames > 0);
        if (wacc && racc) chk("no_collide", 32'(bus.wr_bank != bus.rd_bank), 32'd1);
        if (!we_n && !wacc) m_wovf = 1;
        if (!re_n && !racc) m_runf = 1;
        if (racc) begin
            exp = m_mem[m_rb * DEPTH + ra];
            sb.push_back(exp);
            m_rd_data = exp;
        end
        if (wacc) m_mem[m_wb * DEPTH + wa] = wd;
        if (wacc && wl) begin m_frames++; m_wb = (m_wb + 1) % NB; end
        if (racc && rl) begin m_frames--; m_rb = (m_rb + 1) % NB; end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(bus.rd_valid), 32'(racc));
        if (bus.rd_valid) begin
            if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else                chk("rd_data", bus.rd_data, sb.pop_front());
        end
        chk("rd_hold", bus.rd_data, m_rd_data);
        check_state();
        bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 1, 0, 0);
    endtask

    int exp_wb3 [4] = '{1, 2, 0, 1};
    int exp_rb3 [4] = '{0, 1, 2, 0};

    initial begin
        bus.wr_en = 1; bus.rd_en = 1; bus.wr_last = 0; bus.rd_last = 0;
        bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_data = '0;
        b3.wr_en = 1; b3.rd_en = 1; b3.wr_last = 0; b3.rd_last = 0;
        b3.wr_addr = '0; b3.rd_addr = '0; b3.wr_data = '0;
        #1;
        do_reset();

        // 3-bank instance: one close, then three simultaneous close+release
        for (int k = 0; k < 4; k++) begin
            b3.wr_en = 1'b0; b3.wr_last = 1'b1; b3.wr_addr = '0; b3.wr_data = 32'(k);
            b3.rd_en = (k == 0); b3.rd_last = 1'b1; b3.rd_addr = '0;
            @(posedge clk);
            #1;
            chk("b3_frames",  32'(b3.frames),  32'd1);
            chk("b3_wr_bank", 32'(b3.wr_bank), 32'(exp_wb3[k]));
            chk("b3_rd_bank", 32'(b3.rd_bank), 32'(exp_rb3[k]));
        end
        b3.wr_en = 1'b1; b3.rd_en = 1'b1;

        // fill bank 0, read it back without releasing
        for (int i = 0; i < 4; i++) step(0, i, 32'hA0 + i, i == 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, i, 0);
        idle();

        // fill bank 1 -> full, then an overflowing write
        step(0, 0, 32'hB0, 1, 1, 0, 0);
        step(0, 0, 32'hDEAD, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);

        // simultaneous close and release at frames == 1
        step(0, 0, 32'hC0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);

        // underflow, then a read idle cycle to check hold
        step(1, 0, 0, 0, 0, 5, 0);
        idle();

        // streaming: continuous write and read over three frames
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++)
                step(0, i, 32'h100 * (f + 1) + i, i == 3, 0, i, i == 3);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, i, i == 3);
        idle();

        // reset mid-frame
        do_reset();
        step(0, 0, 32'h55, 1, 1, 0, 0);
        step(0, 0, 32'h66, 0, 1, 0, 0);
        step(0, 1, 32'h67, 0, 1, 0, 0);
        do_reset();
        idle();
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
